// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler that shares one fixed-latency pipelined FP32 adder among NREQ requesters.
// Optional build macro FP_SCHED_PRIO_EN gives requester 0 fixed highest priority.
module fp_add_scheduler #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 5,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          adder_a,
  output logic [31:0]          adder_b,
  input  logic [31:0]          adder_sum,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_sum,
  output logic                 busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [CW-1:0]      cnt [NREQ];
  logic [IDW-1:0]     rr_ptr;
  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]     tag_id [LATENCY];
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    rr_elig;
  logic               grant_any;
  logic [IDW-1:0]     grant_idx;
  int                 idx;

  // A credit returned by this cycle's response is reusable in the same cycle,
  // so a requester at its limit can issue alongside its own response.
  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    eligible  = '0;
    rr_elig   = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = !rst && req_valid[i] &&
                    ((cnt[i] - CW'(rsp_valid[i])) < CW'(MAX_OUT));
    end
    rr_elig = eligible;
`ifdef FP_SCHED_PRIO_EN
    rr_elig[0] = 1'b0;
    if (eligible[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && rr_elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    adder_a   = '0;
    adder_b   = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      adder_a = req_a[32*grant_idx +: 32];
      adder_b = req_b[32*grant_idx +: 32];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_v[LATENCY-1]) rsp_valid[tag_id[LATENCY-1]] = 1'b1;
  end

  assign rsp_sum = adder_sum;
  assign busy    = |tag_v;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= grant_any;
      for (int s = 1; s < LATENCY; s++) tag_v[s] <= tag_v[s-1];
    end
  end

  // NOTE: tag_id is left unreset; tag_v alone qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_idx;
    for (int s = 1; s < LATENCY; s++) tag_id[s] <= tag_id[s-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
`ifdef FP_SCHED_PRIO_EN
    end else if (grant_any && grant_idx != '0) begin
`else
    end else if (grant_any) begin
`endif
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && !rsp_valid[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (!req_ready[i] && rsp_valid[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_chk
    a_cnt_max : assert property (@(posedge clk) disable iff (rst)
      cnt[g] <= CW'(MAX_OUT));
    a_cnt_underflow : assert property (@(posedge clk) disable iff (rst)
      (rsp_valid[g] && !req_ready[g]) |-> (cnt[g] != '0));
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler with a behavioural 5-stage FP32 adder and an
// arbitration reference model built from per-requester in-flight counts.
module tb_fp_add_scheduler;

  localparam int NREQ    = 4;
  localparam int LATENCY = 5;
  localparam int MAX_OUT = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        adder_a, adder_b, adder_sum, rsp_sum;
  logic [NREQ-1:0]    rsp_valid;
  logic               busy;

  int ia [NREQ];
  int ib [NREQ];
  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    int          cyc;
    logic [31:0] sum;
  } ent_t;
  ent_t sb [$];
  int   cyc = 0;
  int   mrr = 0;

  fp_add_scheduler #(.NREQ(NREQ), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact integer-to-FP32 encoding for non-negative values below 2**24.
  function automatic logic [31:0] int_to_fp(input int v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if ((v >> i) & 1) p = i;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic real fp_to_real(input logic [31:0] f);
    int  e;
    real r;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural adder: no reset, fixed latency, cannot stall.
  logic [31:0] add_pipe [LATENCY];
  always @(posedge clk) begin
    add_pipe[0] <= real_to_fp(fp_to_real(adder_a) + fp_to_real(adder_b));
    for (int s = 1; s < LATENCY; s++) add_pipe[s] <= add_pipe[s-1];
  end
  assign adder_sum = add_pipe[LATENCY-1];

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: in-flight count per requester comes from the scoreboard.
  function automatic int model_grant();
    int  infl [NREQ];
    bit  elig [NREQ];
    int  j;
    for (int i = 0; i < NREQ; i++) infl[i] = 0;
    foreach (sb[k]) infl[sb[k].id]++;
    if (sb.size() > 0 && sb[0].cyc + LATENCY == cyc) infl[sb[0].id]--;
    for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && (infl[i] < MAX_OUT);
`ifdef FP_SCHED_PRIO_EN
    if (elig[0]) return 0;
    elig[0] = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      j = (mrr + k) % NREQ;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int          g;
    bit          busy_exp;
    ent_t        e;
    logic [NREQ-1:0] rdy_exp;
    cyc++;
    if (rst) begin
      check("reset_outputs", {req_ready, rsp_valid, busy, adder_a} == '0,
            64'({req_ready, rsp_valid, busy, adder_a}), 64'h0);
      sb.delete();
      mrr = 0;
    end else begin
      busy_exp = (sb.size() > 0) && (sb[0].cyc < cyc);
      g = model_grant();
      rdy_exp = (g >= 0) ? NREQ'(1 << g) : '0;
      check("busy", busy == busy_exp, 64'(busy), 64'(busy_exp));
      check("req_ready", req_ready == rdy_exp, 64'(req_ready), 64'(rdy_exp));
      if (g >= 0)
        check("adder_ops", {adder_a, adder_b} == {int_to_fp(ia[g]), int_to_fp(ib[g])},
              {adder_a, adder_b}, {int_to_fp(ia[g]), int_to_fp(ib[g])});
      else
        check("adder_bubble", {adder_a, adder_b} == 64'h0, {adder_a, adder_b}, 64'h0);

      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1'b0, 64'(rsp_valid), 64'h0);
        end else begin
          e = sb.pop_front();
          check("rsp_time", e.cyc + LATENCY == cyc, 64'(cyc), 64'(e.cyc + LATENCY));
          check("rsp_id", rsp_valid == NREQ'(1 << e.id), 64'(rsp_valid), 64'(1 << e.id));
          check("rsp_sum", rsp_sum == e.sum, 64'(rsp_sum), 64'(e.sum));
        end
      end else if (sb.size() > 0 && sb[0].cyc + LATENCY <= cyc) begin
        e = sb.pop_front();
        check("rsp_missing", 1'b0, 64'(rsp_valid), 64'(1 << e.id));
      end

      if (g >= 0) begin
        sb.push_back('{id: g, cyc: cyc, sum: int_to_fp(ia[g] + ib[g])});
`ifdef FP_SCHED_PRIO_EN
        if (g != 0) mrr = (g + 1) % NREQ;
`else
        mrr = (g + 1) % NREQ;
`endif
      end
    end
  end

  task automatic set_req(input int i, input bit v, input int a, input int b);
    ia[i] = a;
    ib[i] = b;
    req_valid[i] = v;
    req_a[32*i +: 32] = int_to_fp(a);
    req_b[32*i +: 32] = int_to_fp(b);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0);
    step(n);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0);
    step(3);
    rst = 1'b0;

    // Single issue from requester 1: 1.0 + 1.0
    set_req(1, 1'b1, 1, 1);
    step(1);
    idle(8);

    // All requesters continuously valid; requester i adds 1.0 + i.0
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1, i);
    step(20);
    idle(8);

    // Credit limit on requester 2
    set_req(2, 1'b1, 5, 7);
    step(8);
    idle(8);

    // Bubbles after drain
    idle(10);

    // Reset while operations are in flight
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 10 + i, 20);
    step(2);
    #1 rst = 1'b1;
    step(1);
    rst = 1'b0;
    idle(8);
    set_req(2, 1'b1, 3, 4);
    set_req(3, 1'b1, 6, 6);
    step(1);
    idle(8);

    // Requesters 0 and 3 competing
    set_req(0, 1'b1, 2, 2);
    set_req(3, 1'b1, 9, 1);
    step(12);
    idle(8);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 9) < 6, $urandom_range(0, 1000), $urandom_range(0, 1000));
      step(1);
    end
    idle(10);

    check("drained", sb.size() == 0, 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
